ula_muldiv: RTL

- Parametrised multi-cycle multiply/divide unit with HI/LO registers; extends the R-type ALU-control decode (alu_op = 2'b10, funct field) to MULT/MULTU/DIV/DIVU/MFHI/MFLO/MTHI/MTLO.
- Sits in EX beside the ALU; owns HI/LO and raises a stall to the pipeline while an iterative operation is in flight.
- Width-generic: DATA_W-bit operands, 2*DATA_W-bit product.

---
 rtl/ula_pkg.sv | 34 +++
 rtl/ula_muldiv_if.sv | 19 +
 rtl/ula_muldiv_step.sv | 30 +++
 rtl/ula_muldiv.sv | 123 ++++++++++++
 4 files changed

// File: rtl/ula_pkg.sv
// ula_pkg: shared ALU-op classes, ALU operation codes, R-type funct codes and muldiv FSM states
package ula_pkg;
  localparam logic [1:0] ALU_OP_ADD = 2'b00;
  localparam logic [1:0] ALU_OP_SUB = 2'b01;
  localparam logic [1:0] ALU_OP_R   = 2'b10;
  localparam logic [3:0] ULA_AND = 4'b0000;
  localparam logic [3:0] ULA_OR  = 4'b0001;
  localparam logic [3:0] ULA_ADD = 4'b0010;
  localparam logic [3:0] ULA_SUB = 4'b0110;
  localparam logic [3:0] ULA_SLT = 4'b0111;
  localparam logic [3:0] ULA_NOR = 4'b1100;
  localparam logic [5:0] F_MFHI  = 6'b010000;
  localparam logic [5:0] F_MTHI  = 6'b010001;
  localparam logic [5:0] F_MFLO  = 6'b010010;
  localparam logic [5:0] F_MTLO  = 6'b010011;
  localparam logic [5:0] F_MULT  = 6'b011000;
  localparam logic [5:0] F_MULTU = 6'b011001;
  localparam logic [5:0] F_DIV   = 6'b011010;
  localparam logic [5:0] F_DIVU  = 6'b011011;
  localparam logic [5:0] F_ADD   = 6'b100000;
  localparam logic [5:0] F_ADDU  = 6'b100001;
  localparam logic [5:0] F_SUB   = 6'b100010;
  localparam logic [5:0] F_SUBU  = 6'b100011;
  localparam logic [5:0] F_AND   = 6'b100100;
  localparam logic [5:0] F_OR    = 6'b100101;
  localparam logic [5:0] F_XOR   = 6'b100110;
  localparam logic [5:0] F_NOR   = 6'b100111;
  localparam logic [5:0] F_SLT   = 6'b101010;
  typedef logic [1:0] state_t;
  localparam state_t S_IDLE = 2'd0;
  localparam state_t S_MUL  = 2'd1;
  localparam state_t S_DIV  = 2'd2;
  localparam state_t S_FIX  = 2'd3;
endpackage

// File: rtl/ula_muldiv_if.sv
// ula_muldiv_if: EX-stage decode inputs and HI/LO/stall outputs of the multiply/divide unit
interface ula_muldiv_if #(parameter int DATA_W = 32);
  logic [1:0]        alu_op;
  logic [5:0]        funct;
  logic              issue;
  logic [DATA_W-1:0] rs_val;
  logic [DATA_W-1:0] rt_val;
  logic              stall;
  logic              busy;
  logic              done;
  logic [DATA_W-1:0] hi;
  logic [DATA_W-1:0] lo;
  logic [DATA_W-1:0] mf_result;
  logic              mf_valid;
  modport master (output alu_op, funct, issue, rs_val, rt_val,
                  input stall, busy, done, hi, lo, mf_result, mf_valid);
  modport slave  (input alu_op, funct, issue, rs_val, rt_val,
                  output stall, busy, done, hi, lo, mf_result, mf_valid);
endinterface

// File: rtl/ula_muldiv_step.sv
// ula_muldiv_step: one radix-2 shift-add iteration, or one restoring-divide iteration when ULA_MULDIV_DIV_EN is defined
module ula_muldiv_step #(parameter int DATA_W = 32) (
`ifdef ULA_MULDIV_DIV_EN
  input  logic              is_div_i,
`endif
  input  logic [DATA_W-1:0] acc_i,
  input  logic [DATA_W-1:0] lsw_i,
  input  logic [DATA_W-1:0] opnd_i,
  output logic [DATA_W-1:0] acc_o,
  output logic [DATA_W-1:0] lsw_o
);
  logic [DATA_W:0] sum;
`ifdef ULA_MULDIV_DIV_EN
  logic [DATA_W:0] sh;
  logic [DATA_W:0] diff;
`endif
  // multiply: add multiplicand on multiplier LSB then shift {acc,lsw} right; divide: shift left, keep difference if non-negative
  always_comb begin
    sum = {1'b0, acc_i} + (lsw_i[0] ? {1'b0, opnd_i} : '0);
`ifdef ULA_MULDIV_DIV_EN
    sh = {acc_i, lsw_i[DATA_W-1]};
    diff = sh - {1'b0, opnd_i};
    acc_o = is_div_i ? (diff[DATA_W] ? sh[DATA_W-1:0] : diff[DATA_W-1:0]) : sum[DATA_W:1];
    lsw_o = is_div_i ? {lsw_i[DATA_W-2:0], ~diff[DATA_W]} : {sum[0], lsw_i[DATA_W-1:1]};
`else
    acc_o = sum[DATA_W:1];
    lsw_o = {sum[0], lsw_i[DATA_W-1:1]};
`endif
  end
endmodule

// File: rtl/ula_muldiv.sv
// ula_muldiv: iterative MULT/MULTU (and DIV/DIVU when ULA_MULDIV_DIV_EN is defined) unit owning HI/LO, with MFHI/MFLO/MTHI/MTLO
module ula_muldiv
  import ula_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int CNT_W  = $clog2(DATA_W) + 1
) (
  input logic             clk,
  input logic             rst_n,
  ula_muldiv_if.slave     bus
);
  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [DATA_W-1:0]   acc_q, acc_d, lsw_q, lsw_d, opnd_q, opnd_d, hi_q, hi_d, lo_q, lo_d;
  logic                done_q, done_d, neg_q, neg_d, nrem_q, nrem_d, div_q, div_d, dz_q, dz_d;
  logic                r_type, is_mul, is_div, md_op, hl_op, sgn, sa, sb, dz;
  logic [DATA_W-1:0]   mag_a, mag_b, st_acc, st_lsw, quo, rem;
  logic [2*DATA_W-1:0] prod;
  assign r_type = bus.issue && bus.alu_op == ALU_OP_R;
  assign is_mul = bus.funct == F_MULT || bus.funct == F_MULTU;
`ifdef ULA_MULDIV_DIV_EN
  assign is_div = bus.funct == F_DIV || bus.funct == F_DIVU;
`else
  assign is_div = 1'b0;
`endif
  assign md_op = r_type && (is_mul || is_div);
  assign hl_op = r_type && bus.funct[5:2] == F_MFHI[5:2];
  assign sgn   = ~bus.funct[0];
  assign sa    = sgn & bus.rs_val[DATA_W-1];
  assign sb    = sgn & bus.rt_val[DATA_W-1];
  assign mag_a = sa ? -bus.rs_val : bus.rs_val;
  assign mag_b = sb ? -bus.rt_val : bus.rt_val;
  assign dz    = is_div && bus.rt_val == '0;
  assign prod  = neg_q ? -{acc_q, lsw_q} : {acc_q, lsw_q};
  assign quo   = dz_q ? '1 : neg_q ? -lsw_q : lsw_q;
  assign rem   = dz_q ? lsw_q : nrem_q ? -acc_q : acc_q;
  ula_muldiv_step #(.DATA_W(DATA_W)) u_step (
`ifdef ULA_MULDIV_DIV_EN
    .is_div_i(div_q),
`endif
    .acc_i(acc_q),
    .lsw_i(lsw_q),
    .opnd_i(opnd_q),
    .acc_o(st_acc),
    .lsw_o(st_lsw)
  );
  // next state: accept/latch in IDLE, iterate in MUL/DIV, sign-fix and commit HI/LO in FIX
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    lsw_d   = lsw_q;
    opnd_d  = opnd_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    done_d  = 1'b0;
    neg_d   = neg_q;
    nrem_d  = nrem_q;
    div_d   = div_q;
    dz_d    = dz_q;
    if (state_q == S_IDLE && md_op) begin
      state_d = dz ? S_FIX : is_div ? S_DIV : S_MUL;
      cnt_d   = CNT_W'(DATA_W);
      acc_d   = '0;
      lsw_d   = dz ? bus.rs_val : is_div ? mag_a : mag_b;
      opnd_d  = is_div ? mag_b : mag_a;
      neg_d   = sa ^ sb;
      nrem_d  = sa;
      div_d   = is_div;
      dz_d    = dz;
    end else if (state_q == S_IDLE && hl_op && bus.funct == F_MTHI) begin
      hi_d = bus.rs_val;
    end else if (state_q == S_IDLE && hl_op && bus.funct == F_MTLO) begin
      lo_d = bus.rs_val;
    end else if (state_q == S_MUL || state_q == S_DIV) begin
      acc_d   = st_acc;
      lsw_d   = st_lsw;
      cnt_d   = cnt_q - CNT_W'(1);
      state_d = cnt_q == CNT_W'(1) ? S_FIX : state_q;
    end else if (state_q == S_FIX) begin
      {hi_d, lo_d} = div_q ? {rem, quo} : prod;
      done_d  = 1'b1;
      state_d = S_IDLE;
    end
  end
  // registers with synchronous active-low reset; reset aborts any operation in flight
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      acc_q   <= '0;
      lsw_q   <= '0;
      opnd_q  <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      done_q  <= 1'b0;
      neg_q   <= 1'b0;
      nrem_q  <= 1'b0;
      div_q   <= 1'b0;
      dz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      lsw_q   <= lsw_d;
      opnd_q  <= opnd_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      done_q  <= done_d;
      neg_q   <= neg_d;
      nrem_q  <= nrem_d;
      div_q   <= div_d;
      dz_q    <= dz_d;
    end
  end
  assign bus.stall     = (md_op || hl_op) && state_q != S_IDLE;
  assign bus.busy      = state_q != S_IDLE;
  assign bus.done      = done_q;
  assign bus.hi        = hi_q;
  assign bus.lo        = lo_q;
  assign bus.mf_valid  = r_type && (bus.funct == F_MFHI || bus.funct == F_MFLO);
  assign bus.mf_result = !bus.mf_valid ? '0 : bus.funct == F_MFHI ? hi_q : lo_q;
endmodule
